// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl -- UART transmit sequencer
//
// Double-buffers one character (holding register + shift register), frames it
// as start / data (LSB first) / optional parity / stop, and times every serial
// bit with an internal divider. Owns the TXRDY and TX-overrun status flags.
//
// Optional feature: define TX_PARITY_EN to build the PARITY state and parity
// generator. Without it, parity_en and parity_odd are ignored and every frame
// is start + DATA_BITS + stop.
//
// Parameters:
//   DATA_BITS     data bits per frame (5..8)
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   tx_load     single-cycle write strobe for tx_data
//   tx_data     character to transmit
//   parity_en   1 = append parity bit (TX_PARITY_EN builds only)
//   parity_odd  1 = odd parity, 0 = even parity
//   ovr_clr     clears tx_ovr (an overrun in the same cycle wins)
//   tx          serial line, registered, idles high
//   tx_rdy      holding register empty, host may load
//   tx_busy     a frame is in progress
//   tx_done     one-cycle pulse in the last cycle of the stop bit
//   tx_ovr      sticky overrun flag (load attempted while tx_rdy = 0)
// -----------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_load,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 ovr_clr,
    output logic                 tx,
    output logic                 tx_rdy,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_ovr
);

    localparam int DIV_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] BIT_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state_reg, state_next;
    logic [DIV_W-1:0]       div_reg, div_next;
    logic [IDX_W-1:0]       bit_reg, bit_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic [DATA_BITS-1:0]   hold_reg;
    logic                   tx_reg, tx_next;
    logic                   rdy_reg;
    logic                   ovr_reg;

    logic bit_end;
    logic xfer;       // holding register -> shifter this cycle
    logic load_ok;    // accepted load
    logic load_bad;   // load while holding register full -> overrun

    assign bit_end  = (div_reg == DIV_LAST);
    assign load_ok  = tx_load & rdy_reg;
    assign load_bad = tx_load & ~rdy_reg;

`ifdef TX_PARITY_EN
    // Parity settings are captured at the transfer so a mid-frame change of
    // parity_en / parity_odd cannot corrupt the frame being sent.
    logic par_en_reg;
    logic par_bit_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_en_reg  <= 1'b0;
            par_bit_reg <= 1'b0;
        end else if (xfer) begin
            par_en_reg  <= parity_en;
            par_bit_reg <= (^hold_reg) ^ parity_odd;
        end
    end
`else
    logic unused_par_inputs;
    assign unused_par_inputs = parity_en ^ parity_odd;
`endif

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        xfer       = 1'b0;

        // The divider only runs while a frame is on the line.
        if (state_reg != IDLE) begin
            div_next = bit_end ? '0 : div_reg + DIV_W'(1);
        end

        case (state_reg)
            IDLE: begin
                if (!rdy_reg) begin
                    xfer       = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    bit_next   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    if (bit_reg == BIT_LAST) begin
`ifdef TX_PARITY_EN
                        state_next = par_en_reg ? PARITY : STOP;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_next = bit_reg + IDX_W'(1);
                    end
                end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    // A held character follows straight on, no idle gap.
                    if (!rdy_reg) begin
                        xfer       = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (xfer) begin
            shift_next = hold_reg;
            div_next   = '0;
        end
    end

    // Line level for the current state; registered so tx is glitch-free and
    // lags the state register by one clock.
    always_comb begin
        tx_next = 1'b1;
        case (state_reg)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_reg[0];
`ifdef TX_PARITY_EN
            PARITY:  tx_next = par_bit_reg;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            div_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            hold_reg  <= '0;
            tx_reg    <= 1'b1;
            rdy_reg   <= 1'b1;
            ovr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            div_reg   <= div_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;

            if (load_ok) begin
                hold_reg <= tx_data;
            end

            // Set-over-reset flags. Transfer and accepted load are mutually
            // exclusive, so the ordering for tx_rdy is only formal.
            if (xfer) begin
                rdy_reg <= 1'b1;
            end else if (load_ok) begin
                rdy_reg <= 1'b0;
            end

            if (load_bad) begin
                ovr_reg <= 1'b1;
            end else if (ovr_clr) begin
                ovr_reg <= 1'b0;
            end
        end
    end

    assign tx      = tx_reg;
    assign tx_rdy  = rdy_reg;
    assign tx_busy = (state_reg != IDLE);
    assign tx_done = (state_reg == STOP) && bit_end;
    assign tx_ovr  = ovr_reg;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ctrl -- self-checking bench for uart_tx_ctrl
//
// The reference model is a timeline: every accepted character is a frame with
// a load edge and a start edge, and the expected line level, flags and pulses
// at any edge are computed from those numbers. Accepted characters are also
// queued; a monitor pops one per tx_done pulse and decodes the recorded line
// to confirm data, parity and timing.
// -----------------------------------------------------------------------------
module tb_uart_tx_ctrl;

    localparam int DB   = 8;
    localparam int CPB  = 4;
    localparam int MAXC = 8192;
`ifdef TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic          clk;
    logic          rst;
    logic          tx_load;
    logic [DB-1:0] tx_data;
    logic          parity_en;
    logic          parity_odd;
    logic          ovr_clr;
    logic          tx;
    logic          tx_rdy;
    logic          tx_busy;
    logic          tx_done;
    logic          tx_ovr;

    uart_tx_ctrl #(
        .DATA_BITS    (DB),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_load    (tx_load),
        .tx_data    (tx_data),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .ovr_clr    (ovr_clr),
        .tx         (tx),
        .tx_rdy     (tx_rdy),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_ovr     (tx_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc = number of rising edges seen so far (edges numbered from 1)
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int data;
        int load_t;
        int start;
    } frame_t;

    frame_t fr[$];      // timeline of accepted frames since last reset
    frame_t sb_q[$];    // scoreboard: frames awaiting their tx_done
    int     ovr_set_q[$];
    int     ovr_clr_q[$];
    logic   p_en_h  [0:MAXC];
    logic   p_odd_h [0:MAXC];
    logic   txh     [0:MAXC];

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;
    bit rand_par = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    function automatic int flen(int s);
        int pbit;
        pbit = 0;
        if (PB != 0 && s >= 0 && s <= MAXC && p_en_h[s]) pbit = 1;
        return (2 + DB + pbit) * CPB;
    endfunction

    function automatic logic par_of(int d, logic odd);
        int ones;
        ones = 0;
        for (int i = 0; i < DB; i++) ones += (d >> i) & 1;
        return logic'(ones % 2) ^ odd;
    endfunction

    // Bit index 0 = start, 1..DB = data LSB first, then parity (if any), stop.
    function automatic logic fbit(frame_t f, int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DB) return logic'((f.data >> (idx - 1)) & 1);
        if (idx == DB + 1 && flen(f.start) > (2 + DB) * CPB)
            return par_of(f.data, p_odd_h[f.start]);
        return 1'b1;
    endfunction

    // tx after edge e reflects the frame position after edge e-1.
    function automatic logic tx_at(int e);
        foreach (fr[i]) begin
            if (fr[i].start <= e - 1 && e - 1 < fr[i].start + flen(fr[i].start))
                return fbit(fr[i], (e - 1 - fr[i].start) / CPB);
        end
        return 1'b1;
    endfunction

    function automatic logic rdy_at(int e);
        foreach (fr[i]) if (fr[i].load_t <= e && e < fr[i].start) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic busy_at(int e);
        foreach (fr[i]) if (fr[i].start <= e && e < fr[i].start + flen(fr[i].start)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic done_at(int e);
        foreach (fr[i]) if (e == fr[i].start + flen(fr[i].start) - 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic ovr_at(int e);
        int ls, lc;
        ls = -1;
        lc = -1;
        foreach (ovr_set_q[i]) if (ovr_set_q[i] <= e && ovr_set_q[i] > ls) ls = ovr_set_q[i];
        foreach (ovr_clr_q[i]) if (ovr_clr_q[i] <= e && ovr_clr_q[i] > lc) lc = ovr_clr_q[i];
        return (ls >= 0) && (ls >= lc);
    endfunction

    // ---------------- stimulus ----------------
    // Drives inputs for the next edge, records them in the model, then
    // returns 1 time unit after that edge.
    task automatic tick(input bit ld, input int data, input bit clr, input bit r);
        int t;
        int s;
        frame_t f;
        t = cyc + 1;
        if (rand_par) begin
            if ($urandom_range(0, 7) == 0) parity_en  = ~parity_en;
            if ($urandom_range(0, 7) == 0) parity_odd = ~parity_odd;
        end
        tx_load = ld;
        tx_data = data[DB-1:0];
        ovr_clr = clr;
        rst     = r;
        if (t <= MAXC) begin
            p_en_h[t]  = parity_en;
            p_odd_h[t] = parity_odd;
        end
        if (!r) begin
            if (ld) begin
                if (rdy_at(t - 1)) begin
                    s = t + 1;
                    if (fr.size() > 0 && fr[$].start + flen(fr[$].start) > s)
                        s = fr[$].start + flen(fr[$].start);
                    f.data   = data & ((1 << DB) - 1);
                    f.load_t = t;
                    f.start  = s;
                    fr.push_back(f);
                    sb_q.push_back(f);
                end else begin
                    ovr_set_q.push_back(t);
                end
            end
            if (clr) ovr_clr_q.push_back(t);
        end
        @(posedge clk);
        #1;
        if (r) begin
            fr.delete();
            sb_q.delete();
            ovr_set_q.delete();
            ovr_clr_q.delete();
        end
    endtask

    task automatic wait_rdy();
        int w;
        w = 0;
        while (!tx_rdy && w < 200) begin
            tick(1'b0, 0, 1'b0, 1'b0);
            w++;
        end
        chk("rdy_wait_in_budget", w < 200, 1);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((tx_busy || !tx_rdy) && w < 400) begin
            tick(1'b0, 0, 1'b0, 1'b0);
            w++;
        end
        chk("drain_in_budget", w < 400, 1);
        repeat (2) tick(1'b0, 0, 1'b0, 1'b0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    int e;
    always @(negedge clk) begin
        if (chk_en) begin
            e = cyc;
            if (e <= MAXC) txh[e] = tx;
            chk("tx", tx, tx_at(e));
            chk("tx_rdy", tx_rdy, rdy_at(e));
            chk("tx_busy", tx_busy, busy_at(e));
            chk("tx_done", tx_done, done_at(e));
            chk("tx_ovr", tx_ovr, ovr_at(e));
            if (tx_done) begin
                chk("sb_frame_pending", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    frame_t f;
                    int s, len, got;
                    f   = sb_q.pop_front();
                    s   = f.start;
                    len = flen(s);
                    chk("frame_end_cycle", e, s + len - 1);
                    if (s + len + CPB < MAXC) begin
                        chk("frame_start_bit", txh[s + 1 + CPB / 2], 0);
                        got = 0;
                        for (int i = 0; i < DB; i++)
                            got |= int'(txh[s + 1 + (i + 1) * CPB + CPB / 2]) << i;
                        chk("frame_data", got, f.data);
                        if (len > (2 + DB) * CPB)
                            chk("frame_parity", txh[s + 1 + (DB + 1) * CPB + CPB / 2],
                                par_of(f.data, p_odd_h[s]));
                    end
                end
            end
        end
    end

    initial begin
        #(MAXC * 10);
        $display("FAIL watchdog: simulation exceeded %0d cycles", MAXC);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    int load_edge;
    int rst_edge;
    initial begin
        rst        = 1'b1;
        tx_load    = 1'b0;
        tx_data    = '0;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        ovr_clr    = 1'b0;

        repeat (3) tick(1'b0, 0, 1'b0, 1'b1);
        @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_tx_rdy", tx_rdy, 1);
        chk("reset_tx_busy", tx_busy, 0);
        chk("reset_tx_done", tx_done, 0);
        chk("reset_tx_ovr", tx_ovr, 0);
        tick(1'b0, 0, 1'b0, 1'b0);
        chk_en = 1'b1;
        repeat (3) tick(1'b0, 0, 1'b0, 1'b0);

        // Basic frame
        tick(1'b1, 'hA5, 1'b0, 1'b0);
        drain();

        // Back-to-back
        tick(1'b1, 'h00, 1'b0, 1'b0);
        wait_rdy();
        tick(1'b1, 'hFF, 1'b0, 1'b0);
        drain();

        // Overrun, then clear colliding with another overrun, then clear alone
        tick(1'b1, 'h11, 1'b0, 1'b0);
        wait_rdy();
        tick(1'b1, 'h22, 1'b0, 1'b0);
        tick(1'b1, 'h33, 1'b0, 1'b0);
        tick(1'b1, 'h44, 1'b1, 1'b0);
        tick(1'b0, 0, 1'b1, 1'b0);
        drain();

        // Parity (no parity bit when the feature is compiled out)
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        tick(1'b1, 'h07, 1'b0, 1'b0);
        drain();
        parity_odd = 1'b1;
        tick(1'b1, 'h07, 1'b0, 1'b0);
        drain();
        parity_en  = 1'b0;
        parity_odd = 1'b0;

        // Reset during DATA bit 3 with a byte held and overrun set
        tick(1'b1, 'h05, 1'b0, 1'b0);
        load_edge = cyc;
        wait_rdy();
        tick(1'b1, 'h5A, 1'b0, 1'b0);
        tick(1'b1, 'h99, 1'b0, 1'b0);
        rst_edge = load_edge + 1 + 4 * CPB + 2;
        while (cyc + 1 < rst_edge) tick(1'b0, 0, 1'b0, 1'b0);
        tick(1'b0, 0, 1'b0, 1'b1);
        @(negedge clk);
        chk("midrst_tx", tx, 1);
        chk("midrst_tx_rdy", tx_rdy, 1);
        chk("midrst_tx_busy", tx_busy, 0);
        chk("midrst_tx_ovr", tx_ovr, 0);
        repeat (2 * (3 + DB) * CPB) tick(1'b0, 0, 1'b0, 1'b0);

        // Randomized traffic, including mid-frame parity setting changes
        rand_par = 1'b1;
        repeat (1500) begin
            tick($urandom_range(0, 5) == 0, int'($urandom_range(0, (1 << DB) - 1)),
                 $urandom_range(0, 19) == 0, 1'b0);
        end
        rand_par = 1'b0;
        drain();
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
